// File: rtl/id_stage_pipe_pkg.sv
// id_pkg: opcodes, ALU op codes, immediate formats and decode helpers for the ID stage
package id_pkg;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
    ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    alu_op_e    alu;
    logic       unsig;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // Unknown opcodes fall back to R so every field is treated as a register
  function automatic imm_fmt_e fmt_of(logic [6:0] op);
    case (op)
      OP_IMM, LOAD, JALR: return FMT_I;
      STORE:              return FMT_S;
      BRANCH:             return FMT_B;
      LUI, AUIPC:         return FMT_U;
      JAL:                return FMT_J;
      default:            return FMT_R;
    endcase
  endfunction

  function automatic alu_op_e alu_of(logic [2:0] f3, logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF, writeback and EX-side signals of the decode stage
interface id_stage_pipe_if #(parameter int XLEN = 32);
  logic            if_valid, id_ready, flush, wb_we, ex_valid, ex_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc, wb_data, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      wb_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [3:0]      ex_alu_op;
  logic            ex_unsig, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal;
  modport master (
    output if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr,
           ex_rd_addr, ex_alu_op, ex_unsig, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal
  );
  modport slave (
    input  if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr,
           ex_rd_addr, ex_alu_op, ex_unsig, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal
  );
endinterface

// File: rtl/id_stage_pipe_regfile_bypass.sv
// regfile_bypass: x0-hardwired register file, two read ports with same-cycle write-through
module regfile_bypass #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);
  localparam int AW = $clog2(NREG);
  logic [XLEN-1:0] r_mem [NREG];
  logic            w_wen;
  assign w_wen = i_we && i_waddr != 5'd0 && {1'b0, i_waddr} < 6'(NREG);
  // Entry 0 is cleared on reset and never written, so it always reads 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    else if (w_wen) r_mem[i_waddr[AW-1:0]] <= i_wdata;
  assign o_rd1 = (w_wen && i_waddr == i_ra1) ? i_wdata : ({1'b0, i_ra1} < 6'(NREG)) ? r_mem[i_ra1[AW-1:0]] : '0;
  assign o_rd2 = (w_wen && i_waddr == i_ra2) ? i_wdata : ({1'b0, i_ra2} < 6'(NREG)) ? r_mem[i_ra2[AW-1:0]] : '0;
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I/E decode, register read, load-use stall and ID/EX slot
module id_stage_pipe import id_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic             clk,
  input logic             rst_n,
  id_stage_pipe_if.slave  bus
);
  logic [31:0]     w_in, w_imm32;
  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  imm_fmt_e        w_fmt;
  ctrl_t           w_ctrl, r_ctrl;
  logic [XLEN-1:0] w_imm, w_rs1d, w_rs2d, r_pc, r_rs1d, r_rs2d, r_imm;
  logic            r_valid, w_adv, w_stall, w_take, w_ill, w_snp1, w_snp2;
  assign w_in  = bus.if_instr;
  assign w_opc = w_in[6:0];
  assign w_f3  = w_in[14:12];
  assign w_f7  = w_in[31:25];
  assign w_fmt = fmt_of(w_opc);
  // Decode: unused register fields are zeroed so hazards and snoops never match them
  always_comb begin
    w_ctrl = '0;
    w_ctrl.rs1 = (w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? w_in[19:15] : 5'd0;
    w_ctrl.rs2 = (w_fmt inside {FMT_R, FMT_S, FMT_B}) ? w_in[24:20] : 5'd0;
    w_ctrl.rd  = (w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) ? w_in[11:7] : 5'd0;
    w_ill = !(w_opc inside {OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC})
          || (w_opc == OP && !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5))))
          || {1'b0, w_ctrl.rs1} >= 6'(NREG) || {1'b0, w_ctrl.rs2} >= 6'(NREG) || {1'b0, w_ctrl.rd} >= 6'(NREG);
    w_ctrl.alu = (w_opc == LUI) ? ALU_PASS_B
               : (w_opc == OP) ? alu_of(w_f3, w_f7[5])
               : (w_opc == OP_IMM) ? alu_of(w_f3, w_f3 == 3'd5 && w_f7[5])
               : (w_opc == BRANCH) ? (w_f3[2] ? (w_f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB)
               : ALU_ADD;
    w_ctrl.unsig = ((w_opc == OP || w_opc == OP_IMM) && w_f3 == 3'd3)
                 || (w_opc == BRANCH && w_f3[2:1] == 2'b11) || (w_opc == LOAD && w_f3[2:1] == 2'b10);
    w_ctrl.reg_we  = w_ctrl.rd != 5'd0 && !w_ill;
    w_ctrl.mem_rd  = w_opc == LOAD && !w_ill;
    w_ctrl.mem_wr  = w_opc == STORE && !w_ill;
    w_ctrl.branch  = w_opc == BRANCH;
    w_ctrl.jump    = w_opc == JAL || w_opc == JALR;
    w_ctrl.illegal = w_ill;
    w_imm32 = (w_fmt == FMT_I) ? {{20{w_in[31]}}, w_in[31:20]}
            : (w_fmt == FMT_S) ? {{20{w_in[31]}}, w_in[31:25], w_in[11:7]}
            : (w_fmt == FMT_B) ? {{19{w_in[31]}}, w_in[31], w_in[7], w_in[30:25], w_in[11:8], 1'b0}
            : (w_fmt == FMT_U) ? {w_in[31:12], 12'b0}
            : (w_fmt == FMT_J) ? {{11{w_in[31]}}, w_in[31], w_in[19:12], w_in[20], w_in[30:21], 1'b0}
            : 32'd0;
    w_imm = XLEN'($signed(w_imm32));
  end
  regfile_bypass #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk(clk), .rst_n(rst_n), .i_we(bus.wb_we), .i_waddr(bus.wb_addr), .i_wdata(bus.wb_data),
    .i_ra1(w_ctrl.rs1), .i_ra2(w_ctrl.rs2), .o_rd1(w_rs1d), .o_rd2(w_rs2d)
  );
  assign w_adv   = !r_valid || bus.ex_ready;
  assign w_stall = r_valid && r_ctrl.mem_rd && r_ctrl.rd != 5'd0 && (r_ctrl.rd == w_ctrl.rs1 || r_ctrl.rd == w_ctrl.rs2);
  assign w_take  = bus.if_valid && !w_stall;
  assign w_snp1  = bus.wb_we && bus.wb_addr != 5'd0 && bus.wb_addr == r_ctrl.rs1;
  assign w_snp2  = bus.wb_we && bus.wb_addr != 5'd0 && bus.wb_addr == r_ctrl.rs2;
  assign bus.id_ready = bus.flush || (w_adv && !w_stall);
  // ID/EX slot: flush kills, advance loads instruction or bubble, hold snoops writeback
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_pc    <= '0;
      r_rs1d  <= '0;
      r_rs2d  <= '0;
      r_imm   <= '0;
    end else if (bus.flush) r_valid <= 1'b0;
    else if (w_adv) begin
      r_valid <= w_take;
      if (w_take) begin
        r_ctrl <= w_ctrl;
        r_pc   <= bus.if_pc;
        r_rs1d <= w_rs1d;
        r_rs2d <= w_rs2d;
        r_imm  <= w_imm;
      end
    end else begin
      if (w_snp1) r_rs1d <= bus.wb_data;
      if (w_snp2) r_rs2d <= bus.wb_data;
    end
  assign bus.ex_valid    = r_valid;
  assign bus.ex_pc       = r_pc;
  assign bus.ex_rs1_data = r_rs1d;
  assign bus.ex_rs2_data = r_rs2d;
  assign bus.ex_imm      = r_imm;
  assign bus.ex_rs1_addr = r_ctrl.rs1;
  assign bus.ex_rs2_addr = r_ctrl.rs2;
  assign bus.ex_rd_addr  = r_ctrl.rd;
  assign bus.ex_alu_op   = r_ctrl.alu;
  assign bus.ex_unsig    = r_ctrl.unsig;
  assign bus.ex_reg_we   = r_ctrl.reg_we;
  assign bus.ex_mem_rd   = r_ctrl.mem_rd;
  assign bus.ex_mem_wr   = r_ctrl.mem_wr;
  assign bus.ex_branch   = r_ctrl.branch;
  assign bus.ex_jump     = r_ctrl.jump;
  assign bus.ex_illegal  = r_ctrl.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vectors for id_stage_pipe (NREG=32 main DUT, NREG=16 for RV32E checks)
module tb_id_stage_pipe;
  logic clk, rst_n;
  int   n_chk = 0, n_pass = 0;
  id_stage_pipe_if #(.XLEN(32)) bus_a ();
  id_stage_pipe_if #(.XLEN(32)) bus_b ();
  id_stage_pipe #(.XLEN(32), .NREG(32)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  id_stage_pipe #(.XLEN(32), .NREG(16)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus_a.if_valid = v;
    bus_a.if_instr = instr;
    bus_a.if_pc    = pc;
  endtask
  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus_a.wb_we   = we;
    bus_a.wb_addr = a;
    bus_a.wb_data = d;
  endtask
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    bus_a.flush = 1'b0; bus_a.ex_ready = 1'b1;
    bus_b.if_valid = 1'b0; bus_b.if_instr = 32'h0; bus_b.if_pc = 32'h0; bus_b.flush = 1'b0;
    bus_b.wb_we = 1'b0; bus_b.wb_addr = 5'd0; bus_b.wb_data = 32'h0; bus_b.ex_ready = 1'b1;
    tick; tick;
    chk("rst_valid", bus_a.ex_valid, 0);
    chk("rst_imm", bus_a.ex_imm, 0);
    chk("rst_rd", bus_a.ex_rd_addr, 0);
    chk("rst_we", bus_a.ex_reg_we, 0);
    rst_n = 1'b1;
    drive(1'b1, 32'h00500093, 32'h100);
    bus_b.if_valid = 1'b1; bus_b.if_instr = 32'h00100893;
    #1 chk("addi_rdy", bus_a.id_ready, 1);
    tick;
    chk("addi_valid", bus_a.ex_valid, 1);
    chk("addi_imm", bus_a.ex_imm, 5);
    chk("addi_rd", bus_a.ex_rd_addr, 1);
    chk("addi_alu", bus_a.ex_alu_op, 0);
    chk("addi_we", bus_a.ex_reg_we, 1);
    chk("addi_pc", bus_a.ex_pc, 32'h100);
    chk("e_valid", bus_b.ex_valid, 1);
    chk("e_ill", bus_b.ex_illegal, 1);
    chk("e_we", bus_b.ex_reg_we, 0);
    bus_b.if_valid = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h104);
    wb(1'b1, 5'd1, 32'h1234);
    tick;
    wb(1'b0, 5'd0, 32'h0);
    chk("byp_rs1d", bus_a.ex_rs1_data, 32'h1234);
    chk("byp_rs2d", bus_a.ex_rs2_data, 0);
    chk("byp_rd", bus_a.ex_rd_addr, 3);
    chk("byp_imm", bus_a.ex_imm, 0);
    drive(1'b1, 32'h0000A283, 32'h108);
    tick;
    chk("lw_memrd", bus_a.ex_mem_rd, 1);
    chk("lw_rs1d", bus_a.ex_rs1_data, 32'h1234);
    chk("lw_rd", bus_a.ex_rd_addr, 5);
    drive(1'b1, 32'h00528333, 32'h10C);
    #1 chk("lu_rdy0", bus_a.id_ready, 0);
    tick;
    chk("lu_bubble", bus_a.ex_valid, 0);
    chk("lu_rdy1", bus_a.id_ready, 1);
    tick;
    chk("lu_valid", bus_a.ex_valid, 1);
    chk("lu_rd", bus_a.ex_rd_addr, 6);
    chk("lu_rs1a", bus_a.ex_rs1_addr, 5);
    chk("lu_memrd", bus_a.ex_mem_rd, 0);
    drive(1'b1, 32'hFE000EE3, 32'h110);
    tick;
    chk("beq_imm", bus_a.ex_imm, 32'hFFFFFFFC);
    chk("beq_alu", bus_a.ex_alu_op, 1);
    chk("beq_br", bus_a.ex_branch, 1);
    chk("beq_we", bus_a.ex_reg_we, 0);
    drive(1'b1, 32'h002081B3, 32'h114);
    tick;
    chk("hold_rs2d0", bus_a.ex_rs2_data, 0);
    drive(1'b0, 32'h0, 32'h0);
    bus_a.ex_ready = 1'b0;
    wb(1'b1, 5'd2, 32'hBEEF);
    #1 chk("hold_rdy", bus_a.id_ready, 0);
    tick;
    wb(1'b0, 5'd0, 32'h0);
    chk("snoop_rs2d", bus_a.ex_rs2_data, 32'hBEEF);
    chk("snoop_rs1d", bus_a.ex_rs1_data, 32'h1234);
    chk("snoop_rd", bus_a.ex_rd_addr, 3);
    chk("snoop_pc", bus_a.ex_pc, 32'h114);
    chk("snoop_valid", bus_a.ex_valid, 1);
    tick;
    chk("hold2_valid", bus_a.ex_valid, 1);
    chk("hold2_rs2d", bus_a.ex_rs2_data, 32'hBEEF);
    bus_a.flush = 1'b1;
    drive(1'b1, 32'h123453B7, 32'h118);
    #1 chk("fl_rdy", bus_a.id_ready, 1);
    tick;
    chk("fl_valid", bus_a.ex_valid, 0);
    bus_a.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick;
    chk("fl_drop", bus_a.ex_valid, 0);
    bus_a.ex_ready = 1'b1;
    drive(1'b1, 32'h123453B7, 32'h118);
    tick;
    chk("lui_imm", bus_a.ex_imm, 32'h12345000);
    chk("lui_alu", bus_a.ex_alu_op, 10);
    chk("lui_rd", bus_a.ex_rd_addr, 7);
    drive(1'b1, 32'h0020B433, 32'h11C);
    tick;
    chk("sltu_alu", bus_a.ex_alu_op, 4);
    chk("sltu_uns", bus_a.ex_unsig, 1);
    chk("sltu_rs2d", bus_a.ex_rs2_data, 32'hBEEF);
    drive(1'b1, 32'h042081B3, 32'h120);
    tick;
    chk("f7_ill", bus_a.ex_illegal, 1);
    chk("f7_we", bus_a.ex_reg_we, 0);
    chk("f7_valid", bus_a.ex_valid, 1);
    drive(1'b1, 32'h008000EF, 32'h200);
    tick;
    chk("jal_imm", bus_a.ex_imm, 8);
    chk("jal_jump", bus_a.ex_jump, 1);
    chk("jal_we", bus_a.ex_reg_we, 1);
    chk("jal_pc", bus_a.ex_pc, 32'h200);
    rst_n = 1'b0;
    #1 chk("arst_valid", bus_a.ex_valid, 0);
    chk("arst_imm", bus_a.ex_imm, 0);
    tick;
    rst_n = 1'b1;
    drive(1'b1, 32'h002081B3, 32'h300);
    tick;
    chk("post_valid", bus_a.ex_valid, 1);
    chk("post_rs1d", bus_a.ex_rs1_data, 0);
    chk("post_rs2d", bus_a.ex_rs2_data, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised RV32I/RV32E instruction-decode pipeline stage, placed between IF and EX. It decodes all base formats and generates the immediate internally from the opcode, with no external format select. It reads an internal register file with write-through bypass and detects load-use hazards against its own output slot. Results are registered into an ID/EX slot with valid/ready handshakes on both sides.

Parameters:
XLEN, 32, datapath width; 32 or 64; immediates sign-extended to XLEN.
NREG, 32, architectural registers; 32 (RV32I) or 16 (RV32E).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset; asynchronous, active-low.
if_valid / id_ready  in / out  1 / 1  IF handshake.
if_instr / if_pc  in  32 / XLEN  instruction and its PC.
flush  in  1  kill the slot and the incoming instruction.
wb_we / wb_addr / wb_data  in  1 / 5 / XLEN  register-file write port.
ex_valid / ex_ready  out / in  1 / 1  EX handshake.
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each.
ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  5 each.
ex_alu_op  out  4  ALU operation, encoded per the package.
ex_unsig  out  1  unsigned compare or load.
ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal  out  1 each.

Behaviour:
- Reset (async): all outputs 0 and all registers 0; ex_valid=0.
- Register file: x0 reads 0 and ignores writes. A write occurs when wb_we && wb_addr!=0.
- Read bypass: when wb_we and wb_addr equals a nonzero rs in the same cycle, the read returns wb_data.
- Slot advance: adv = !ex_valid || ex_ready.
- Stall: stall = ex_valid && ex_mem_rd && ex_rd_addr!=0 && (ex_rd_addr matches a used rs of if_instr).
  - rs2 counts as used only for R, S and B formats.
- Handshake: id_ready = adv && !stall.
- On adv, the slot loads the decoded instruction when if_valid && !stall && !flush; otherwise it loads a bubble (ex_valid=0).
- Load-use timing: exactly one bubble; id_ready is low for exactly one cycle.
- Flush: ex_valid<=0 next cycle regardless of ex_ready. The same-cycle incoming instruction is dropped; id_ready=1 during flush.
- Hold snoop: while ex_valid && !ex_ready, a writeback to a nonzero ex_rs1_addr/ex_rs2_addr updates ex_rs1_data/ex_rs2_data. All other slot fields are held stable.
- Latency: 1 cycle from IF acceptance to ex_valid.
- Immediate formats:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All formats are sign-extended from bit 31 to XLEN. R-type gives ex_imm=0.
- ALU op mapping:
  - From funct3/funct7; SUB/SRA select on funct7[5].
  - Loads, stores, AUIPC and JAL/JALR use ADD; branches use SUB/SLT/SLTU; LUI uses PASS_B.
  - ex_unsig=1 for SLTU, SLTIU, BLTU, BGEU, LBU and LHU.
- Illegal instruction (unknown opcode, bad R-type funct7, or any rs/rd >= NREG):
  - ex_illegal=1; ex_reg_we, ex_mem_rd and ex_mem_wr forced to 0.
  - The instruction still occupies the slot with ex_valid=1.
- ex_reg_we=0 whenever rd=0.

Decomposition:
- Package id_pkg holds:
  - Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
  - ALU op codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
  - Immediate-format enum (R, I, S, B, U, J).
- Sub-module regfile_bypass(XLEN, NREG): async-reset storage, two read ports with bypass, one write port.

Test Plan:
1. ADDI x1,x0,5 (0x00500093), ex_ready=1 -> next cycle ex_valid=1, ex_imm=5, ex_rd_addr=1, ex_alu_op=ADD, ex_reg_we=1.
2. wb x1=0x1234 in the same cycle as ADD x3,x1,x2 (0x002081B3) -> ex_rs1_data=0x1234.
3. LW x5,0(x1) (0x0000A283), then ADD x6,x5,x5 (0x00528333) -> id_ready=0 for one cycle, one ex_valid=0 bubble, ADD follows.
4. BEQ x0,x0,-4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC, ex_alu_op=SUB, ex_branch=1.
5. Hold with ex_ready=0 after ADD x3,x1,x2, then wb x2=0xBEEF -> ex_rs2_data=0xBEEF; all other fields stable.
6. flush while holding -> ex_valid=0 next cycle. With NREG=16, ADDI x17,x0,1 -> ex_illegal=1, ex_reg_we=0. rst_n low mid-stream -> ex_valid=0 immediately and regs read 0.
